// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states, captured request.
// Also holds the alignment/legality rule so the FSM and any checker agree on it.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITE,
      RESP
   } lsu_state_t;

   typedef struct packed {
      logic [2:0]  funct3;
      logic        store;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Undefined encodings are folded into the error response alongside misalignment.
   function automatic logic misaligned(input logic [2:0] funct3,
                                       input logic       store,
                                       input logic [1:0] offset);
      logic bad;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = offset[0];
         F3_W:    bad = (offset != 2'b00);
         F3_BU:   bad = store;
         F3_HU:   bad = store || offset[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword select with extension, store byte-enable merge.
// Zero latency; no flow control of its own.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rd,
   input  logic [31:0] merge,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [3:0]  be;
   logic [31:0] wrep;

   always_comb begin
      lane_b     = rd[{offset, 3'b000} +: 8];
      lane_h     = offset[1] ? rd[31:16] : rd[15:0];
      load_data  = rd;
      be         = 4'b1111;
      wrep       = wdata;
      store_data = merge;

      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_BU:   load_data = {24'b0, lane_b};
         F3_HU:   load_data = {16'b0, lane_h};
         default: load_data = rd;
      endcase

      // Store data is replicated across lanes so the byte enables alone pick the target.
      case (funct3)
         F3_B: begin
            be   = 4'b0001 << offset;
            wrep = {4{wdata[7:0]}};
         end
         F3_H: begin
            be   = offset[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wrep = wdata;
         end
      endcase

      for (int i = 0; i < 4; i++) begin
         store_data[8*i +: 8] = be[i] ? wrep[8*i +: 8] : merge[8*i +: 8];
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM driving a word-wide memory; sub-word stores use read-modify-write.
// Latency 2 (load/SW), 3 (SB/SH), 1 (error); req_ready only when idle, no response backpressure.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_funct3,
   input  logic                  req_store,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [31:0]           mem_wd,
   input  logic [31:0]           mem_rd
);

   lsu_state_t  state;
   lsu_req_t    req_q;
   logic [31:0] merge_q;
   logic [31:0] load_data;
   logic [31:0] store_data;
   logic        unused_addr_hi;

   lsu_align u_align (
      .funct3     (req_q.funct3),
      .offset     (req_q.addr[1:0]),
      .rd         (mem_rd),
      .merge      (merge_q),
      .wdata      (req_q.wdata),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Upper address bits wrap the access within the memory.
   assign unused_addr_hi = ^req_q.addr[31:ADDR_WIDTH+2];
   assign mem_a          = req_q.addr[ADDR_WIDTH+1:2];

   // Gated by reset so a pending RMW write never lands on the reset edge.
   assign mem_we = !reset && ((state == ACCESS && req_q.store && req_q.funct3 == F3_W) ||
                              state == WRITE);
   assign mem_wd = mem_we ? store_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         req_q      <= '0;
         merge_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q      <= '{funct3: req_funct3, store: req_store,
                                  addr: req_addr, wdata: req_wdata};
                  resp_rdata <= '0;
                  req_ready  <= 1'b0;
                  if (misaligned(req_funct3, req_store, req_addr[1:0])) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     resp_err <= 1'b0;
                     state    <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!req_q.store) begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (req_q.funct3 == F3_W) begin
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  merge_q <= mem_rd;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_lsu;
   import lsu_pkg::*;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_funct3;
   logic          req_store;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [31:0]   mem_wd;
   logic [31:0]   mem_rd;

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];
   int n_checks = 0;
   int n_fail   = 0;

   lsu #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_store  (req_store),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a];
   always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

   // One transaction: reports response data, latency in cycles after acceptance and writes seen.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                         output int lat, output int we_n, output int we_cyc,
                         output logic [31:0] we_dat);
      int g;
      rdata = '0; err = 1'b0; lat = 0; we_n = 0; we_cyc = 0; we_dat = '0;
      @(negedge clk);
      g = 0;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (mem_we) begin
            we_n++;
            we_cyc = c;
            we_dat = mem_wd;
         end
         if (resp_valid) begin
            lat   = c;
            rdata = resp_rdata;
            err   = resp_err;
            break;
         end
      end
   endtask

   // Reference: architectural effect of one access on a byte-addressed view of ref_mem.
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] er, output logic ee,
                        output int elat);
      int size; bit legal; bit sgn; int off; int w; logic [31:0] word;
      size = 4; legal = 1'b1; sgn = 1'b0;
      case (f3)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: begin size = 1; legal = !st; end
         3'd5: begin size = 2; legal = !st; end
         default: legal = 1'b0;
      endcase
      off = int'(addr[1:0]);
      w   = int'(addr[7:2]);
      er = '0; ee = 1'b0; elat = 1;
      if (!legal || (off % size) != 0) begin
         ee = 1'b1;
         return;
      end
      word = ref_mem[w];
      if (st) begin
         for (int i = 0; i < size; i++) word[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
         ref_mem[w] = word;
         elat = (size == 4) ? 2 : 3;
      end else begin
         er = word >> (off * 8);
         if (size == 1) er = (sgn && er[7]) ? (er | 32'hFFFF_FF00) : (er & 32'h0000_00FF);
         else if (size == 2) er = (sgn && er[15]) ? (er | 32'hFFFF_0000) : (er & 32'h0000_FFFF);
         elat = 2;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready got %b want 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid got %b want 0", resp_valid); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset resp_rdata got %h want 0", resp_rdata); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset resp_err got %b want 0", resp_err); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we got %b want 0", mem_we); end
      n_checks++; if (mem_a !== '0) begin n_fail++; $display("FAIL reset mem_a got %h want 0", mem_a); end
      n_checks++; if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset mem_wd got %h want 0", mem_wd); end
      reset = 1'b0;
   endtask

   task automatic test_sw_lw();
      logic [31:0] rd, wdt; logic e; int lat, wn, wc;
      do_req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, rd, e, lat, wn, wc, wdt);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw latency got %0d want 2", lat); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw err got %b want 0", e); end
      n_checks++; if (wn !== 1 || wc !== 1) begin n_fail++; $display("FAIL sw write count/cycle got %0d/%0d want 1/1", wn, wc); end
      n_checks++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw mem[4] got %h want deadbeef", mem[4]); end
      do_req(1'b0, F3_W, 32'h10, 32'h0, rd, e, lat, wn, wc, wdt);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw data got %h want deadbeef", rd); end
      n_checks++; if (lat !== 2 || wn !== 0) begin n_fail++; $display("FAIL lw latency/writes got %0d/%0d want 2/0", lat, wn); end
      // Address bits above the memory wrap: 0x110 is word 4 again.
      do_req(1'b0, F3_W, 32'h0000_0110, 32'h0, rd, e, lat, wn, wc, wdt);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw wrap got %h want deadbeef", rd); end
   endtask

   task automatic test_rmw();
      logic [31:0] rd, wdt; logic e; int lat, wn, wc;
      do_req(1'b1, F3_W, 32'h10, 32'h1122_3344, rd, e, lat, wn, wc, wdt);
      do_req(1'b1, F3_B, 32'h13, 32'h0000_00AA, rd, e, lat, wn, wc, wdt);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb latency got %0d want 3", lat); end
      n_checks++; if (wn !== 1 || wc !== 2) begin n_fail++; $display("FAIL sb write count/cycle got %0d/%0d want 1/2", wn, wc); end
      n_checks++; if (wdt !== 32'hAA22_3344) begin n_fail++; $display("FAIL sb mem_wd got %h want aa223344", wdt); end
      do_req(1'b1, F3_H, 32'h12, 32'h0000_5566, rd, e, lat, wn, wc, wdt);
      n_checks++; if (lat !== 3 || e !== 1'b0) begin n_fail++; $display("FAIL sh latency/err got %0d/%b want 3/0", lat, e); end
      n_checks++; if (mem[4] !== 32'h5566_3344) begin n_fail++; $display("FAIL sh mem[4] got %h want 55663344", mem[4]); end
   endtask

   task automatic test_load_ext();
      logic [31:0] rd, wdt; logic e; int lat, wn, wc;
      logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_H, F3_B, F3_HU};
      logic [31:0] ads [5] = '{32'h10, 32'h10, 32'h12, 32'h13, 32'h10};
      logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_5566, 32'h0000_0055, 32'h0000_3380};
      do_req(1'b1, F3_W, 32'h10, 32'h5566_3380, rd, e, lat, wn, wc, wdt);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3s[i], ads[i], 32'h0, rd, e, lat, wn, wc, wdt);
         n_checks++;
         if (rd !== exps[i] || lat !== 2) begin
            n_fail++;
            $display("FAIL load_ext[%0d] got %h lat %0d want %h lat 2", i, rd, lat, exps[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, last, nresp;
      acc = 0; last = 0; nresp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = '0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         if (resp_valid) begin
            nresp++;
            n_checks++;
            if (resp_rdata !== 32'h5566_3380) begin n_fail++; $display("FAIL b2b data got %h want 55663380", resp_rdata); end
         end
         if (req_valid && req_ready) begin
            if (acc > 0) begin
               n_checks++;
               if (c - last !== 3) begin n_fail++; $display("FAIL b2b spacing got %0d want 3", c - last); end
            end
            last = c;
            acc++;
         end else if (acc == 4) begin
            req_valid = 1'b0;
         end
      end
      n_checks++; if (nresp !== 4) begin n_fail++; $display("FAIL b2b responses got %0d want 4", nresp); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd, wdt; logic e; int lat, wn, wc;
      logic        sts[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  f3s[4] = '{F3_W, F3_H, 3'b100, 3'b011};
      logic [31:0] ads[4] = '{32'h11, 32'h13, 32'h10, 32'h10};
      for (int i = 0; i < 4; i++) begin
         do_req(sts[i], f3s[i], ads[i], 32'hFFFF_FFFF, rd, e, lat, wn, wc, wdt);
         n_checks++;
         if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || wn !== 0) begin
            n_fail++;
            $display("FAIL misaligned[%0d] got lat %0d err %b rdata %h writes %0d want 1 1 0 0", i, lat, e, rd, wn);
         end
      end
      n_checks++; if (mem[4] !== 32'h5566_3380) begin n_fail++; $display("FAIL misaligned mem[4] got %h want 55663380", mem[4]); end
   endtask

   task automatic test_reset_mid_rmw();
      logic [31:0] rd, wdt; logic e; int lat, wn, wc;
      do_req(1'b1, F3_W, 32'h20, 32'h1234_5678, rd, e, lat, wn, wc, wdt);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h21; req_wdata = 32'h99;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw write phase mem_we got %b want 1", mem_we); end
      reset = 1'b1;
      #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset gates mem_we got %b want 0", mem_we); end
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rmw resp_valid got %b want 0", resp_valid); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset rmw req_ready got %b want 1", req_ready); end
      n_checks++; if (mem[8] !== 32'h1234_5678) begin n_fail++; $display("FAIL reset rmw mem[8] got %h want 12345678", mem[8]); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rmw late resp_valid got %b want 0", resp_valid); end
      do_req(1'b0, F3_W, 32'h20, 32'h0, rd, e, lat, wn, wc, wdt);
      n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL reset rmw reload got %h want 12345678", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, wdt, er, addr, wd; logic e, ee, st; logic [2:0] f3; int lat, wn, wc, elat;
      for (int w = 0; w < 64; w++) begin
         wd = $urandom;
         ref_mem[w] = wd;
         do_req(1'b1, F3_W, 32'(w * 4), wd, rd, e, lat, wn, wc, wdt);
      end
      for (int k = 0; k < 150; k++) begin
         st   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom;
         wd   = $urandom;
         model(st, f3, addr, wd, er, ee, elat);
         do_req(st, f3, addr, wd, rd, e, lat, wn, wc, wdt);
         n_checks++;
         if (rd !== er || e !== ee || lat !== elat || wn !== ((st && !ee) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL random[%0d] st %b f3 %0d addr %h: got rdata %h err %b lat %0d writes %0d want %h %b %0d",
                     k, st, f3, addr, rd, e, lat, wn, er, ee, elat);
         end
      end
      for (int w = 0; w < 64; w++) begin
         n_checks++;
         if (mem[w] !== ref_mem[w]) begin n_fail++; $display("FAIL random mem[%0d] got %h want %h", w, mem[w], ref_mem[w]); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      test_reset();
      test_sw_lw();
      test_rmw();
      test_load_ext();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_rmw();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: initiator side of the data-memory port. Accepts one RV32I load or store per transaction from the core datapath, drives the word-addressed, word-wide memory port (`clk`/`we`/`a`/`wd` in, asynchronous `rd` out), and returns sign- or zero-extended load data. Sub-word stores (SB/SH) use read-modify-write, since the memory writes whole words only. Misaligned accesses get an error response and never touch memory.

## Interface
- `ADDR_WIDTH`, 6: memory word-address width; must match the memory instance.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit idle, can accept a request.
- `req_funct3`  in  3: RV32I funct3. Loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores 000 SB, 001 SH, 010 SW.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, in low bits for SB/SH.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned access, valid with `resp_valid`.
- `mem_we`  out  1: memory write enable.
- `mem_a`  out  ADDR_WIDTH: word address, equal to `req_addr[ADDR_WIDTH+1:2]`.
- `mem_wd`  out  32: memory write data.
- `mem_rd`  in  32: memory read data, combinational from `mem_a`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture funct3, store flag, address and wdata into registers.
  - Misaligned goes to RESP with the error flag set:
    - halfword op with `addr[0]`=1;
    - word op with `addr[1:0]`≠0;
    - undefined funct3 (011, 11x; 1xx for stores).
  - Aligned goes to ACCESS.
- **ACCESS**
  - Drive `mem_a` from the captured address.
  - Load: extend the selected byte lane(s) of `mem_rd` into the rdata register, then go to RESP.
  - SW: `mem_we`=1, `mem_wd`=wdata, then go to RESP.
  - SB/SH: capture `mem_rd` into the merge register, then go to WRITE.
- **WRITE**
  - `mem_we`=1.
  - `mem_wd` = merge register with lane `addr[1:0]` (SB) or halfword `addr[1]` (SH) replaced by the low wdata bits.
  - Go to RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - No response backpressure.
- **Load extension**
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - Lane selection uses `addr[1:0]` little-endian: byte 0 = bits 7:0.
- **Outputs**
  - `mem_we` is 0 outside ACCESS(SW) and WRITE.
  - `mem_we` is gated by `!reset`, so no write lands on a reset edge.
  - `req_ready` is 1 only in IDLE.
  - Requests presented while busy are ignored; the core holds them.

## Timing
- Request accepted at edge T, when `req_valid && req_ready`.
- `resp_valid` high in the cycle after:
  - T+2 for loads and SW;
  - T+3 for SB/SH;
  - T+1 for errors.
- `req_ready` rises in the same cycle `resp_valid` falls, i.e. the cycle after RESP.
- Back-to-back throughput: one load every 3 cycles.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0; all capture registers 0.
- **Reset in any state:** next cycle is IDLE with no response. A pending RMW write is dropped and memory is unchanged.
- Address bits above `ADDR_WIDTH+1` are ignored; accesses wrap within the memory.

## Structure
- **Package `lsu_pkg`**
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum `lsu_state_t`;
  - misalignment check function.
- **Sub-module `lsu_align`**, combinational:
  - load lane select and extend;
  - store lane merge (byte-enable generation and word merge).
  - Instantiated once; `lsu` holds only the FSM and registers.

## Test plan
- **LW/SW round trip:** SW addr 0x10, data 0xDEADBEEF.
  - Write to word 4 in ACCESS.
  - `resp_valid` at T+2, `resp_err`=0.
  - LW 0x10 returns 0xDEADBEEF at T+2.
- **Sub-word RMW:** word 4 = 0x11223344; SB addr 0x13, data 0xAA.
  - Read cycle, then WRITE with `mem_wd`=0xAA223344.
  - Response at T+3.
- **SH:** SH addr 0x12, data 0x5566 over 0xAA223344 writes 0x55663344.
- **Load extension:** word 4 = 0x55663380.
  - LB 0x10 → 0xFFFFFF80.
  - LBU 0x10 → 0x00000080.
  - LH 0x12 → 0x00005566.
- **Misaligned:** LW 0x11 and SH 0x13 each give `resp_valid`, `resp_err`=1 at T+1, `resp_rdata`=0, `mem_we` never asserted.
- **Reset mid-RMW:** assert `reset` during WRITE of SB.
  - Memory word unchanged.
  - No `resp_valid`.
  - `req_ready`=1 on the next cycle.
  - A following LW returns the original word.
